// File: rtl/top3_selector_if.sv
// Handshake and candidate bus between the letter classifier, the top-3
// selector and the Viterbi decoder. The selector uses the slave modport;
// the surrounding logic (classifier source + decoder) uses master.
interface top3_selector_if #(
    parameter int PROB_W = 32,
    parameter int CHAR_W = 5
);
    logic                          i_new_word;
    logic                          i_valid;
    logic                          o_ready;
    logic [PROB_W-1:0]             i_logit;
    logic [2:0][PROB_W-1:0]        o_prob;
    logic [2:0][CHAR_W-1:0]        o_char;
    logic                          o_start;
    logic                          o_next;
    logic                          i_stepped;
    logic                          o_busy;

    modport master (
        output i_new_word, i_valid, i_logit, i_stepped,
        input  o_ready, o_prob, o_char, o_start, o_next, o_busy
    );

    modport slave (
        input  i_new_word, i_valid, i_logit, i_stepped,
        output o_ready, o_prob, o_char, o_start, o_next, o_busy
    );
endinterface

// File: rtl/top3_selector.sv
// Top-3 logit selector feeding the Viterbi decoder. Logits arrive one class
// per beat in index order; a running sorted top-3 is kept, presented in
// parallel at frame end, and held until the decoder reports it has stepped.
module top3_selector #(
    parameter int NUM_CLASS = 26,
    parameter int PROB_W    = 32,
    parameter int CHAR_W    = 5
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    top3_selector_if.slave  bus
);

    localparam logic [CHAR_W-1:0] LAST_IDX = CHAR_W'(NUM_CLASS - 1);

    typedef enum logic [1:0] {
        ST_COLLECT,
        ST_EMIT,
        ST_WAIT
    } state_t;

    state_t                 state_q, state_d;
    logic [CHAR_W-1:0]      cnt_q, cnt_d;
    logic [2:0][PROB_W-1:0] slot_prob_q, slot_prob_d;
    logic [2:0][CHAR_W-1:0] slot_char_q, slot_char_d;
    logic [2:0]             slot_vld_q, slot_vld_d;
    logic                   first_q, first_d;
    logic [2:0][PROB_W-1:0] out_prob_q, out_prob_d;
    logic [2:0][CHAR_W-1:0] out_char_q, out_char_d;
    logic                   start_q, start_d;
    logic                   next_q, next_d;

    logic                   accept;
    logic [2:0]             displace;

    assign accept = bus.i_valid && (state_q == ST_COLLECT);

    // A slot yields to the new beat if it is empty or strictly smaller, so equal logits keep the lower index ahead
    always_comb begin
        displace = '0;
        for (int i = 0; i < 3; i++) begin
            displace[i] = !slot_vld_q[i] || (bus.i_logit > slot_prob_q[i]);
        end
    end

    // Next-state, sorted insertion, output capture and decoder pulse generation
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        slot_prob_d = slot_prob_q;
        slot_char_d = slot_char_q;
        slot_vld_d  = slot_vld_q;
        first_d     = first_q;
        out_prob_d  = out_prob_q;
        out_char_d  = out_char_q;
        start_d     = 1'b0;
        next_d      = 1'b0;

        case (state_q)
            ST_COLLECT: begin
                if (accept) begin
                    if (displace[0]) begin
                        slot_prob_d = {slot_prob_q[1], slot_prob_q[0], bus.i_logit};
                        slot_char_d = {slot_char_q[1], slot_char_q[0], cnt_q};
                        slot_vld_d  = {slot_vld_q[1], slot_vld_q[0], 1'b1};
                    end else if (displace[1]) begin
                        slot_prob_d = {slot_prob_q[1], bus.i_logit, slot_prob_q[0]};
                        slot_char_d = {slot_char_q[1], cnt_q, slot_char_q[0]};
                        slot_vld_d  = {slot_vld_q[1], 1'b1, slot_vld_q[0]};
                    end else if (displace[2]) begin
                        slot_prob_d[2] = bus.i_logit;
                        slot_char_d[2] = cnt_q;
                        slot_vld_d[2]  = 1'b1;
                    end

                    if (cnt_q == LAST_IDX) begin
                        cnt_d      = '0;
                        state_d    = ST_EMIT;
                        out_prob_d = slot_prob_d;
                        out_char_d = slot_char_d;
                    end else begin
                        cnt_d = cnt_q + CHAR_W'(1);
                    end
                end
            end
            ST_EMIT: begin
                start_d = first_q;
                next_d  = !first_q;
                first_d = 1'b0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.i_stepped) begin
                    slot_vld_d = '0;
                    state_d    = ST_COLLECT;
                end
            end
            default: begin
                state_d = ST_COLLECT;
            end
        endcase

        if (bus.i_new_word) begin
            first_d = 1'b1;
        end
    end

    // State and datapath registers; reset discards any partial frame
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_COLLECT;
            cnt_q       <= '0;
            slot_prob_q <= '0;
            slot_char_q <= '0;
            slot_vld_q  <= '0;
            first_q     <= 1'b1;
            out_prob_q  <= '0;
            out_char_q  <= '0;
            start_q     <= 1'b0;
            next_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            slot_prob_q <= slot_prob_d;
            slot_char_q <= slot_char_d;
            slot_vld_q  <= slot_vld_d;
            first_q     <= first_d;
            out_prob_q  <= out_prob_d;
            out_char_q  <= out_char_d;
            start_q     <= start_d;
            next_q      <= next_d;
        end
    end

    assign bus.o_ready = (state_q == ST_COLLECT);
    assign bus.o_busy  = (state_q != ST_COLLECT);
    assign bus.o_prob  = out_prob_q;
    assign bus.o_char  = out_char_q;
    assign bus.o_start = start_q;
    assign bus.o_next  = next_q;

endmodule

// File: doc/top3_selector.md
Name: top3_selector

Overview:
- Sits directly upstream of the Viterbi decoder, between the per-frame letter classifier and the decoder.
- Receives one frame of NUM_CLASS unsigned fixed-point logits serially, one class per accepted beat, in class-index order 0..NUM_CLASS-1.
- Keeps a running sorted top-3 of (logit, class index) and presents the three candidates in parallel.
- Drives the decoder's start/next handshake and holds the candidates until the decoder reports it has stepped.

Parameters:
- NUM_CLASS, 26, number of logits per frame; legal range 3..32; index 0 = 'A'.
- PROB_W, 32, logit width, unsigned Q24.8 (LSB = 2^-8).
- CHAR_W, 5, class-index width; must satisfy 2^CHAR_W >= NUM_CLASS.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_new_word  in  1  one-cycle pulse: the next emitted frame starts a new word. Sampled in any state.
- i_valid  in  1  logit beat valid.
- o_ready  out  1  beat accepted when i_valid && o_ready.
- i_logit  in  PROB_W  logit of the current class.
- o_prob  out  3 x PROB_W  top-3 logits, descending; drives decoder i_prob[0:2].
- o_char  out  3 x CHAR_W  matching class indices; drives decoder i_char[0:2].
- o_start  out  1  one-cycle pulse, first frame of a word; drives decoder i_start.
- o_next  out  1  one-cycle pulse, subsequent frames; drives decoder i_next.
- i_stepped  in  1  decoder o_stepped; releases the held frame.
- o_busy  out  1  high in EMIT and WAIT.

Behaviour:
- Reset (async, i_rst_n=0):
  - state=COLLECT, class counter=0, slot-valid bits=0.
  - o_prob = 0, o_char = 0, o_start = 0, o_next = 0, o_busy = 0.
  - first_flag = 1; o_ready = 1 once reset is released.
- States:
  - COLLECT: o_ready = 1.
  - EMIT: lasts exactly 1 cycle.
  - WAIT: o_ready = 0.
- COLLECT, on each accepted beat with class index = counter:
  - Insert into slots 0..2, where slot 0 is the largest.
  - The new entry displaces a slot only if the slot is empty or i_logit > the slot's logit (unsigned, strict).
  - Displaced entries shift down one slot; the slot-2 entry drops out.
  - Ties keep the lower class index ahead.
  - The counter increments on every accepted beat.
- Frame end: a beat accepted with counter == NUM_CLASS-1 is inserted, the counter returns to 0 and the next state is EMIT.
- Output update: o_prob/o_char are copied from the slots on the COLLECT->EMIT edge and are stable from the EMIT cycle until the next frame's EMIT.
- EMIT:
  - Pulse o_start if first_flag = 1, otherwise pulse o_next; exactly one of the two per frame.
  - Clear first_flag; go to WAIT.
- WAIT:
  - Stay until i_stepped = 1 is seen.
  - Then clear the slot-valid bits and return to COLLECT, so o_ready = 1 on the following cycle.
  - i_stepped outside WAIT is ignored.
- i_new_word:
  - Sets first_flag on the next edge in every state.
  - If asserted in the EMIT cycle, the current frame keeps its already-chosen pulse and the flag applies to the next frame.
- Latency: the last beat accepted at edge N gives o_start/o_next high in the cycle after edge N+1, with o_prob/o_char already valid in that cycle.
- i_valid while o_ready = 0: the beat is not consumed and the counter does not move; the source must hold the beat.
- Reset mid-frame: the partial frame is discarded and no pulse is emitted.

Test Plan:
- Frame 1: after reset, stream NUM_CLASS=26 logits, all 0x00008000 except idx19=0x0001028f, idx4=0x0000e625, idx18=0x0000b7bc.
  - Required: o_char = {19,4,18}, o_prob = {0x0001028f,0x0000e625,0x0000b7bc}.
  - Required: one o_start pulse, no o_next, o_ready=0 until i_stepped.
- Second frame without i_new_word, top values idx7=0x0000e2f8, idx10=0x0000dea3, idx3=0x0000c13d (rest smaller).
  - Required: o_char = {7,10,3}, o_next pulse, no o_start.
- Ties: all 26 logits 0x00010000.
  - Required: o_char = {0,1,2}.
- Ascending then descending: logits ascending 1..26 then descending 26..1 on the next frame.
  - Required: first frame o_char = {25,24,23}; second frame o_char = {0,1,2}.
- Backpressure and new word:
  - Hold i_valid=1 during WAIT for 50 cycles, then i_stepped: no extra beats consumed, counter intact.
  - Pulse i_new_word mid-frame: that frame emits o_start.
- Reset mid-frame: assert i_rst_n=0 after 10 beats.
  - Required: all outputs 0, no pulse.
  - Required: the next full 26-beat frame emits o_start with correct top-3.
